// File: rtl/pixel_sample_scheduler.sv
// Raster-order pixel/sample sequencer feeding the ray generator, with a
// stall-aware tag delay line matched to the generator's latency.
module pixel_sample_scheduler #(
  parameter int H_RES       = 800,
  parameter int V_RES       = 600,
  parameter int SPP         = 4,
  parameter int GEN_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       tag_valid,
  output logic [9:0] tag_x,
  output logic [9:0] tag_y,
  output logic       tag_first,
  output logic       tag_last,
  output logic       frame_done,
  output logic       busy
);

  localparam int SW = (SPP > 1) ? $clog2(SPP) : 1;
  localparam int DW = $clog2(GEN_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
    logic       first;
    logic       last;
    logic       fin;
  } tag_t;

  state_t        state, state_next;
  logic [9:0]    x_cnt, y_cnt;
  logic [SW-1:0] s_cnt;
  logic [DW-1:0] drain_cnt;
  logic          issue, s_wrap, x_wrap, y_wrap, final_sample;
  tag_t          stage_in;
  tag_t          pipe [GEN_LATENCY];

  assign issue        = (state == RUN) && !stall;
  assign s_wrap       = (s_cnt == SW'(SPP - 1));
  assign x_wrap       = (x_cnt == 10'(H_RES - 1));
  assign y_wrap       = (y_cnt == 10'(V_RES - 1));
  assign final_sample = s_wrap && x_wrap && y_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // start in IDLE is accepted regardless of stall; DRAIN counts only live cycles
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (issue && final_sample) state_next = DRAIN;
      DRAIN:   if (!stall && drain_cnt == DW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
      s_cnt <= '0;
    end else if (state == IDLE) begin
      x_cnt <= '0;
      y_cnt <= '0;
      s_cnt <= '0;
    end else if (issue) begin
      s_cnt <= s_wrap ? '0 : s_cnt + SW'(1);
      if (s_wrap) x_cnt <= x_wrap ? '0 : x_cnt + 10'd1;
      if (s_wrap && x_wrap) y_cnt <= y_wrap ? '0 : y_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    drain_cnt <= '0;
    else if (issue && final_sample) drain_cnt <= DW'(GEN_LATENCY);
    else if (state == DRAIN && !stall) drain_cnt <= drain_cnt - DW'(1);
  end

  // Stage 0 carries valid=0 outside RUN so the line empties naturally
  always_comb begin
    stage_in       = '0;
    stage_in.valid = (state == RUN);
    stage_in.x     = x_cnt;
    stage_in.y     = y_cnt;
    stage_in.first = (s_cnt == '0);
    stage_in.last  = s_wrap;
    stage_in.fin   = (state == RUN) && final_sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GEN_LATENCY; i++) pipe[i] <= '0;
    end else if (!stall) begin
      for (int i = GEN_LATENCY - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= stage_in;
    end
  end

  assign pixel_x    = x_cnt;
  assign pixel_y    = y_cnt;
  assign tag_valid  = pipe[GEN_LATENCY-1].valid;
  assign tag_x      = pipe[GEN_LATENCY-1].x;
  assign tag_y      = pipe[GEN_LATENCY-1].y;
  assign tag_first  = pipe[GEN_LATENCY-1].first;
  assign tag_last   = pipe[GEN_LATENCY-1].last;
  assign frame_done = pipe[GEN_LATENCY-1].fin;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_pixel_sample_scheduler.sv
// Scoreboard bench for pixel_sample_scheduler on a 4x2 frame, 2 samples/pixel.
module tb_pixel_sample_scheduler;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int S  = 2;
  localparam int GL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [9:0] pixel_x, pixel_y, tag_x, tag_y;
  logic       tag_valid, tag_first, tag_last, frame_done, busy;

  pixel_sample_scheduler #(.H_RES(H), .V_RES(V), .SPP(S), .GEN_LATENCY(GL)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .tag_valid(tag_valid),
    .tag_x(tag_x), .tag_y(tag_y), .tag_first(tag_first), .tag_last(tag_last),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit first;
    bit last;
    bit fin;
    int ts;
  } exp_t;

  exp_t q[$];
  int   vec_count = 0;
  int   miscompares = 0;
  bit   run = 0;
  int   mx = 0, my = 0, ms = 0;
  int   nsc = 0, cyc = 0;
  int   start_cyc = 0, done_cyc = 0, done_count = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".pixel_x"}, pixel_x, 0);
    check_val({tag, ".pixel_y"}, pixel_y, 0);
    check_val({tag, ".tag_valid"}, tag_valid, 0);
    check_val({tag, ".tag_x"}, tag_x, 0);
    check_val({tag, ".tag_y"}, tag_y, 0);
    check_val({tag, ".tag_first"}, tag_first, 0);
    check_val({tag, ".tag_last"}, tag_last, 0);
    check_val({tag, ".frame_done"}, frame_done, 0);
    check_val({tag, ".busy"}, busy, 0);
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance the model
  task automatic do_cycle(input bit st, input bit sl);
    bit   idle_now, exp_valid;
    exp_t e;
    @(negedge clk);
    start = st;
    stall = sl;
    cyc++;
    idle_now = !run && (q.size() == 0);
    check_val("busy", busy, !idle_now);
    if (run || idle_now) begin
      check_val("pixel_x", pixel_x, run ? mx : 0);
      check_val("pixel_y", pixel_y, run ? my : 0);
    end
    if (!sl) begin
      exp_valid = (q.size() > 0) && (q[0].ts + GL == nsc);
      check_val("tag_valid", tag_valid, exp_valid);
      if (exp_valid) begin
        e = q.pop_front();
        check_val("tag_x", tag_x, e.x);
        check_val("tag_y", tag_y, e.y);
        check_val("tag_first", tag_first, e.first);
        check_val("tag_last", tag_last, e.last);
        check_val("frame_done", frame_done, e.fin);
        $display("tag cyc=%0d x=%0d y=%0d first=%0d last=%0d done=%0d",
                 cyc, tag_x, tag_y, tag_first, tag_last, frame_done);
      end else begin
        check_val("frame_done_idle", frame_done, 0);
      end
      if (frame_done === 1'b1) begin
        done_count++;
        done_cyc = cyc;
      end
      if (run) begin
        e.x = mx; e.y = my; e.first = (ms == 0); e.last = (ms == S - 1);
        e.fin = (mx == H - 1) && (my == V - 1) && (ms == S - 1);
        e.ts = nsc;
        q.push_back(e);
        if (e.fin) run = 0;
        ms++;
        if (ms == S) begin
          ms = 0;
          mx++;
          if (mx == H) begin
            mx = 0;
            my++;
            if (my == V) my = 0;
          end
        end
      end
      nsc++;
    end
    if (idle_now && st) begin
      run = 1; mx = 0; my = 0; ms = 0;
      start_cyc = cyc;
      done_count = 0;
    end
  endtask

  // Start a frame and run until the model returns to idle
  task automatic run_frame(input string name, input int stall_lo, input int stall_hi,
                           input int pct, input int sa, input int sb, input int sc,
                           input int exp_lat);
    int  rel;
    bit  sl;
    do_cycle(1, 0);
    rel = 1;
    while ((run || q.size() > 0) && rel < 300) begin
      sl = ((rel >= stall_lo) && (rel <= stall_hi)) || ($urandom_range(99) < pct);
      do_cycle((rel == sa) || (rel == sb) || (rel == sc), sl);
      rel++;
    end
    if (rel >= 300) check_val({name, ".timeout"}, rel, 0);
    check_val({name, ".done_count"}, done_count, 1);
    if (exp_lat > 0) check_val({name, ".done_cycle"}, done_cyc - start_cyc, exp_lat);
    $display("frame %s: start=%0d done=%0d", name, start_cyc, done_cyc);
    repeat (3) do_cycle(0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) do_cycle(0, 0);

    run_frame("plain", 0, -1, 0, 8, 18, 20, 20);
    run_frame("stall3to5", 3, 5, 0, 0, 0, 0, 23);
    run_frame("random", 0, -1, 30, 5, 12, 0, 0);

    // Asynchronous reset in the middle of a frame
    do_cycle(1, 0);
    repeat (7) do_cycle(0, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    q.delete();
    run = 0; mx = 0; my = 0; ms = 0;
    repeat (2) do_cycle(0, 0);
    #2 rst_n = 1'b1;
    run_frame("after_reset", 0, -1, 0, 0, 0, 0, 20);
    run_frame("second", 0, -1, 25, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
